id_ex_stage: RTL
================

# id_ex_stage

Pipeline register between decode (D) and execute (E) of the RV32I 5-stage core. It latches decoded operands and control into the E stage, feeding the EX forwarding mux. It also:
- detects load-use hazards, freezing D and inserting a bubble into E;
- applies the W→D register-file bypass at capture time;
- squashes on taken branches;
- counts bubble cycles.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, bubble-counter width

Ports (clock and reset first):
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- validD  in  1  the D slot holds a real instruction
- rs1D, rs2D, rdD  in  5 each  decoded register indices
- source1D, source2D  in  XLEN each  register-file read data
- immD, pcD  in  XLEN each  immediate and PC
- reg_writeD  in  1  instruction writes rd
- mem_loadD  in  3  load type; 3'b000 = not a load
- mem_storeD  in  2  store type; 2'b00 = not a store
- alu_ctrlD  in  4  ALU operation
- rdW  in  5  W-stage destination register
- distW  in  XLEN  W-stage writeback data
- reg_writeW  in  1  W-stage write enable
- flushE  in  1  a taken branch/jump in E squashes the D instruction
- holdE  in  1  downstream stall (memory busy); freeze E
- stallD  out  1  freeze PC and the IF/ID register this cycle
- validE, rs1E, rs2E, rdE, source1E, source2E, immE, pcE, reg_writeE, mem_loadE, mem_storeE, alu_ctrlE  out  registered counterparts of the D inputs
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- Load-use hazard, combinational: `lu = validD & validE & reg_writeE & (mem_loadE != 0) & (rdE != 0) & ((rdE == rs1D) | (rdE == rs2D))`.
- stallD = (lu & ~flushE) | holdE.
- W bypass at capture: if `reg_writeW & rdW != 0 & rdW == rs1D`, then source1E ← distW; otherwise source1E ← source1D. source2 follows the same rule with rs2D.
- Next-state priority on each clock edge, highest first:
  1. holdE: all E registers keep their values; bubble_cnt is unchanged. flushE is ignored; the branch unit re-asserts it once E advances.
  2. flushE: load NOP.
  3. lu: load NOP and increment bubble_cnt.
  4. Otherwise: load the D inputs, with the bypass applied.
- NOP bundle: validE = 0, reg_writeE = 0, mem_loadE = 0, mem_storeE = 0, rdE = rs1E = rs2E = 0, alu_ctrlE = 0. Data fields (source1E, source2E, immE, pcE) are zeroed.
- D instruction with validD = 0: the bundle is loaded as-is and never raises lu.
- bubble_cnt saturates at all-ones; it never wraps.

## Timing
- Latency: one cycle from D to E.
- Reset: all outputs are 0 immediately on rst_n low, with no clock needed; bubble_cnt = 0. stallD is 0 while in reset.
- Load-use sequence (load in E, dependent instruction in D at cycle t):
  - t: stallD = 1.
  - t+1: E holds a NOP; the load is in M; the dependent instruction is still in D and lu = 0.
  - t+2: the dependent instruction enters E with the load in W; the EX forwarding mux supplies distW. Exactly one bubble per load-use.
- Simultaneous lu and flushE: flush wins; stallD = 0, the counter does not increment.
- Reset deasserted mid-pipeline: E restarts empty, with no spurious stall.

## Structure
- rv32i_pkg holds:
  - MEM_LOAD_NONE = 3'b000 and MEM_STORE_NONE = 2'b00;
  - the load/store and ALU control encodings;
  - a packed id_ex_t bundle and the ID_EX_NOP constant.
- One sub-module, load_use_detect: combinational lu and stallD generation. The W bypass muxes and the registers stay in id_ex_stage.

## Test plan
- Reset: rst_n low mid-cycle with nonzero state → all outputs 0 before the next edge; bubble_cnt = 0.
- Load-use: `lw x5` in E (mem_loadE = 3'b010, rdE = 5), D has rs1D = 5 → stallD = 1 for one cycle, then E = NOP (validE = 0), bubble_cnt = 1, and the dependent instruction reaches E the cycle after.
- No false hazard:
  - rdE = 0 load with rs1D = 0 → stallD = 0;
  - non-load with rdE = rs1D → stallD = 0.
  In both cases the D bundle passes through.
- W bypass: rdW = 7, reg_writeW = 1, distW = 32'hDEADBEEF, rs2D = 7, source2D = 0 → source2E = 32'hDEADBEEF next cycle. The same stimulus with rdW = 0 gives source2E = 0.
- Priority:
  - holdE with flushE and lu all high → E unchanged, counter unchanged;
  - flushE with lu → NOP, stallD = 0, no increment.
- Saturation: force bubble_cnt to all-ones and trigger one more load-use → the count stays at all-ones.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and the D->E pipeline bundle used by the ID/EX register.
package rv32i_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [2:0] MEM_LOAD_NONE = 3'b000;
    localparam logic [2:0] MEM_LOAD_LB   = 3'b001;
    localparam logic [2:0] MEM_LOAD_LW   = 3'b010;
    localparam logic [2:0] MEM_LOAD_LH   = 3'b011;
    localparam logic [2:0] MEM_LOAD_LBU  = 3'b100;
    localparam logic [2:0] MEM_LOAD_LHU  = 3'b101;

    localparam logic [1:0] MEM_STORE_NONE = 2'b00;
    localparam logic [1:0] MEM_STORE_SB   = 2'b01;
    localparam logic [1:0] MEM_STORE_SH   = 2'b10;
    localparam logic [1:0] MEM_STORE_SW   = 2'b11;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    typedef struct packed {
        logic               valid;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [RV_XLEN-1:0] source1;
        logic [RV_XLEN-1:0] source2;
        logic [RV_XLEN-1:0] imm;
        logic [RV_XLEN-1:0] pc;
        logic               reg_write;
        logic [2:0]         mem_load;
        logic [1:0]         mem_store;
        logic [3:0]         alu_ctrl;
    } id_ex_t;

    // A bubble: every control and data field cleared.
    localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection and D-stage stall generation.
module load_use_detect
    import rv32i_pkg::*;
(
    input  logic       rst_ni,
    input  logic       valid_d_i,
    input  logic [4:0] rs1_d_i,
    input  logic [4:0] rs2_d_i,
    input  logic       valid_e_i,
    input  logic       reg_write_e_i,
    input  logic [2:0] mem_load_e_i,
    input  logic [4:0] rd_e_i,
    input  logic       flush_e_i,
    input  logic       hold_e_i,
    output logic       lu_o,
    output logic       stall_d_o
);

    logic rd_match;

    assign rd_match = (rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i);

    assign lu_o = valid_d_i && valid_e_i && reg_write_e_i
               && (mem_load_e_i != MEM_LOAD_NONE) && (rd_e_i != 5'd0) && rd_match;

    // Held low in reset so a downstream hold cannot freeze fetch before E is live.
    assign stall_d_o = rst_ni && ((lu_o && !flush_e_i) || hold_e_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: W->D bypass at capture, load-use bubbles, flush and hold.
// XLEN must match rv32i_pkg::RV_XLEN since the bundle type is fixed-width.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validD,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdD,
    input  logic [XLEN-1:0]  source1D,
    input  logic [XLEN-1:0]  source2D,
    input  logic [XLEN-1:0]  immD,
    input  logic [XLEN-1:0]  pcD,
    input  logic             reg_writeD,
    input  logic [2:0]       mem_loadD,
    input  logic [1:0]       mem_storeD,
    input  logic [3:0]       alu_ctrlD,
    input  logic [4:0]       rdW,
    input  logic [XLEN-1:0]  distW,
    input  logic             reg_writeW,
    input  logic             flushE,
    input  logic             holdE,
    output logic             stallD,
    output logic             validE,
    output logic [4:0]       rs1E,
    output logic [4:0]       rs2E,
    output logic [4:0]       rdE,
    output logic [XLEN-1:0]  source1E,
    output logic [XLEN-1:0]  source2E,
    output logic [XLEN-1:0]  immE,
    output logic [XLEN-1:0]  pcE,
    output logic             reg_writeE,
    output logic [2:0]       mem_loadE,
    output logic [1:0]       mem_storeE,
    output logic [3:0]       alu_ctrlE,
    output logic [CNT_W-1:0] bubble_cnt
);

    id_ex_t            e_q, e_d, cap_bundle;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lu;
    logic              byp1, byp2;

    load_use_detect u_load_use_detect (
        .rst_ni        (rst_n),
        .valid_d_i     (validD),
        .rs1_d_i       (rs1D),
        .rs2_d_i       (rs2D),
        .valid_e_i     (e_q.valid),
        .reg_write_e_i (e_q.reg_write),
        .mem_load_e_i  (e_q.mem_load),
        .rd_e_i        (e_q.rd),
        .flush_e_i     (flushE),
        .hold_e_i      (holdE),
        .lu_o          (lu),
        .stall_d_o     (stallD)
    );

    // The register file writes at the end of W, so a same-cycle read in D is stale.
    assign byp1 = reg_writeW && (rdW != 5'd0) && (rdW == rs1D);
    assign byp2 = reg_writeW && (rdW != 5'd0) && (rdW == rs2D);

    always_comb begin
        cap_bundle           = ID_EX_NOP;
        cap_bundle.valid     = validD;
        cap_bundle.rs1       = rs1D;
        cap_bundle.rs2       = rs2D;
        cap_bundle.rd        = rdD;
        cap_bundle.source1   = byp1 ? distW : source1D;
        cap_bundle.source2   = byp2 ? distW : source2D;
        cap_bundle.imm       = immD;
        cap_bundle.pc        = pcD;
        cap_bundle.reg_write = reg_writeD;
        cap_bundle.mem_load  = mem_loadD;
        cap_bundle.mem_store = mem_storeD;
        cap_bundle.alu_ctrl  = alu_ctrlD;
    end

    always_comb begin
        e_d   = e_q;
        cnt_d = cnt_q;
        if (holdE) begin
            e_d   = e_q;
        end else if (flushE) begin
            e_d = ID_EX_NOP;
        end else if (lu) begin
            e_d = ID_EX_NOP;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            e_d = cap_bundle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= ID_EX_NOP;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end

    assign validE     = e_q.valid;
    assign rs1E       = e_q.rs1;
    assign rs2E       = e_q.rs2;
    assign rdE        = e_q.rd;
    assign source1E   = e_q.source1;
    assign source2E   = e_q.source2;
    assign immE       = e_q.imm;
    assign pcE        = e_q.pc;
    assign reg_writeE = e_q.reg_write;
    assign mem_loadE  = e_q.mem_load;
    assign mem_storeE = e_q.mem_store;
    assign alu_ctrlE  = e_q.alu_ctrl;
    assign bubble_cnt = cnt_q;

endmodule
